// File: rtl/rvga_types.sv
// ---------------------------------------------------------------------------
// rvga_types -- constants shared across the register-slice datapath blocks.
//
// Contents:
//   DEFAULT_WIDTH : default data bits per beat for pipe_reg / pipe_stage.
//
// Holds constants only; the pipeline blocks declare no types of their own.
// ---------------------------------------------------------------------------
package rvga_types;

  localparam int unsigned DEFAULT_WIDTH = 32;

endpackage : rvga_types

// File: rtl/pipe_stage.sv
// ---------------------------------------------------------------------------
// pipe_stage -- one register stage of the pipe_reg elastic pipeline.
//
// Holds a valid bit and a data word. When the stage is ready (load_en) it
// takes the upstream valid, and takes the upstream data only if that valid is
// set, so a bubble moving through leaves the stale word in place. Flush clears
// the valid bit and wins over any load; the data word is never cleared except
// by reset.
//
// Ports:
//   clk     : clock, rising edge
//   rst_n   : asynchronous active-low reset (clears vld and dat)
//   flush   : discard the held beat on this edge
//   load_en : stage readiness; the stage captures its upstream this edge
//   up_vld  : valid of the upstream source (pipe input or previous stage)
//   up_dat  : data of the upstream source
//   vld     : registered valid bit
//   dat     : registered data word
// ---------------------------------------------------------------------------
module pipe_stage #(
  parameter int WIDTH = rvga_types::DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             load_en,
  input  logic             up_vld,
  input  logic [WIDTH-1:0] up_dat,
  output logic             vld,
  output logic [WIDTH-1:0] dat
);

  // NOTE: sequential state uses non-blocking (<=) so every stage samples the
  // pre-edge value of its neighbour; blocking here would let a beat race
  // through several stages in one edge.
  // NOTE: the data word is reset as well as the valid bit so data_o reads 0
  // out of reset; this is a handful of flops, not a memory, so the reset is
  // cheap and never blocks RAM inference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= 1'b0;
      dat <= '0;
    end else if (flush) begin
      vld <= 1'b0;
    end else if (load_en) begin
      vld <= up_vld;
      if (up_vld) begin
        dat <= up_dat;
      end
    end
  end

endmodule : pipe_stage

// File: rtl/pipe_reg.sv
// ---------------------------------------------------------------------------
// pipe_reg -- DEPTH-stage valid/ready register pipeline with flush.
//
// Stage 0 faces the upstream sender, stage DEPTH-1 drives the outputs. The
// ready chain is combinational from ready_i back to ready_o, so an empty
// stage anywhere lets everything upstream of it advance (no bubble penalty)
// and a full pipe still moves one beat per cycle while ready_i is high.
//
// Parameters:
//   WIDTH : data bits per beat (>= 1)
//   DEPTH : number of register stages (>= 1)
//
// Ports:
//   clk_i   : clock, rising edge
//   rst_ni  : asynchronous active-low reset; release must be synchronous
//   flush_i : discard all held beats; the beat on data_i is not accepted
//   v_i     : upstream beat valid
//   data_i  : upstream beat data
//   ready_o : pipe accepts the upstream beat this cycle
//   v_o     : downstream beat valid
//   data_o  : downstream beat data
//   ready_i : downstream accepts the beat
//   count_o : number of occupied stages (registered, not flush-masked)
// ---------------------------------------------------------------------------
module pipe_reg #(
  parameter int WIDTH = rvga_types::DEFAULT_WIDTH,
  parameter int DEPTH = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       flush_i,
  input  logic                       v_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       ready_o,
  output logic                       v_o,
  output logic [WIDTH-1:0]           data_o,
  input  logic                       ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int CW = $clog2(DEPTH + 1);

  if (DEPTH < 1) begin : g_bad_depth
    $error("pipe_reg: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] vld;
  logic [WIDTH-1:0] dat [DEPTH];
  logic [DEPTH-1:0] up_vld;
  logic [WIDTH-1:0] up_dat [DEPTH];
  logic [DEPTH:0]   rdy;

  // A stage can load when it is empty or when the stage after it is loading
  // (i.e. its beat moves on this same edge). Evaluated in one process so the
  // backward chain is a single combinational sweep from ready_i.
  // NOTE: every bit of rdy is given a default before the loop so no path
  // leaves a bit unassigned, which would otherwise infer a latch.
  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = ready_i;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      rdy[k] = !vld[k] || rdy[k+1];
    end
  end

  for (genvar k = 0; k < DEPTH; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign up_vld[k] = v_i;
      assign up_dat[k] = data_i;
    end else begin : g_body
      assign up_vld[k] = vld[k-1];
      assign up_dat[k] = dat[k-1];
    end

    pipe_stage #(
      .WIDTH (WIDTH)
    ) u_stage (
      .clk     (clk_i),
      .rst_n   (rst_ni),
      .flush   (flush_i),
      .load_en (rdy[k]),
      .up_vld  (up_vld[k]),
      .up_dat  (up_dat[k]),
      .vld     (vld[k]),
      .dat     (dat[k])
    );
  end

  // Handshake outputs are masked during flush: nothing enters and nothing is
  // handed downstream on an edge that is about to discard the contents.
  assign ready_o = rdy[0] && !flush_i;
  assign v_o     = vld[DEPTH-1] && !flush_i;
  assign data_o  = dat[DEPTH-1];

  // Occupancy reflects the registered valid bits, so it still shows the
  // pre-flush count during the flush cycle and drops to 0 after the edge.
  assign count_o = CW'($countones(vld));

endmodule : pipe_reg

// File: tb/tb_pipe_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_reg -- self-checking bench for pipe_reg.
//
// Two instances share one stimulus: DEPTH=3 (u_d3) and DEPTH=2 (u_d2), both
// 8 bits wide. Each instance has its own scoreboard queue: a beat is pushed
// when v_i && ready_o is seen before the edge, popped and compared when
// v_o && ready_i is seen, and the queue is emptied on a flush cycle. After
// every edge count_o is compared with the queue occupancy.
// ---------------------------------------------------------------------------
module tb_pipe_reg;

  localparam int W = 8;

  logic         clk;
  logic         rst_n;
  logic         flush;
  logic         v_in;
  logic [W-1:0] data_in;
  logic         rdy_in;

  logic         ready3, v3;
  logic [W-1:0] data3;
  logic [1:0]   cnt3;
  logic         ready2, v2;
  logic [W-1:0] data2;
  logic [1:0]   cnt2;

  logic [W-1:0] q3 [$];
  logic [W-1:0] q2 [$];

  int vectors;
  int miscompares;

  pipe_reg #(.WIDTH(W), .DEPTH(3)) u_d3 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .v_i     (v_in),
    .data_i  (data_in),
    .ready_o (ready3),
    .v_o     (v3),
    .data_o  (data3),
    .ready_i (rdy_in),
    .count_o (cnt3)
  );

  pipe_reg #(.WIDTH(W), .DEPTH(2)) u_d2 (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (flush),
    .v_i     (v_in),
    .data_i  (data_in),
    .ready_o (ready2),
    .v_o     (v2),
    .data_o  (data2),
    .ready_i (rdy_in),
    .count_o (cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at posedge+1 with inputs already applied. Runs the scoreboard on
  // the pre-edge handshake, advances one edge, then checks occupancy.
  task automatic tick();
    #1;
    if (flush) begin
      q3.delete();
      q2.delete();
    end else begin
      if (v3 && rdy_in) begin
        if (q3.size() == 0) check("d3_spurious_beat", 32'(v3), 32'd0);
        else                check("d3_data", 32'(data3), 32'(q3.pop_front()));
      end
      if (v2 && rdy_in) begin
        if (q2.size() == 0) check("d2_spurious_beat", 32'(v2), 32'd0);
        else                check("d2_data", 32'(data2), 32'(q2.pop_front()));
      end
      if (v_in && ready3) q3.push_back(data_in);
      if (v_in && ready2) q2.push_back(data_in);
    end
    @(posedge clk);
    #1;
    check("d3_count", 32'(cnt3), 32'(q3.size()));
    check("d2_count", 32'(cnt2), 32'(q2.size()));
  endtask

  task automatic idle(input int n);
    v_in   = 1'b0;
    flush  = 1'b0;
    rdy_in = 1'b1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n   = 1'b0;
    flush   = 1'b0;
    v_in    = 1'b0;
    data_in = '0;
    rdy_in  = 1'b1;

    // Reset state.
    #12;
    check("rst_d3_v",     32'(v3),     32'd0);
    check("rst_d3_data",  32'(data3),  32'd0);
    check("rst_d3_count", 32'(cnt3),   32'd0);
    check("rst_d3_ready", 32'(ready3), 32'd1);
    check("rst_d2_v",     32'(v2),     32'd0);
    check("rst_d2_count", 32'(cnt2),   32'd0);
    check("rst_d2_ready", 32'(ready2), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Stream into DEPTH=3: 0x11,0x22,0x33 emerge on cycles 3,4,5.
    rdy_in = 1'b1;
    for (int c = 0; c < 7; c++) begin
      v_in    = (c < 3);
      data_in = (c < 3) ? W'(8'h11 * (c + 1)) : '0;
      #1;
      check("stream_d3_v", 32'(v3), 32'((c >= 3) && (c <= 5)));
      if ((c >= 3) && (c <= 5)) check("stream_d3_data", 32'(data3), 32'(8'h11 * (c - 2)));
      tick();
    end
    idle(4);

    // Backpressure on DEPTH=2: A,B accepted, C held until ready_i rises.
    rdy_in  = 1'b0;
    v_in    = 1'b1;
    data_in = 8'h0A;
    #1 check("bp_d2_ready_a", 32'(ready2), 32'd1);
    tick();
    data_in = 8'h0B;
    #1 check("bp_d2_ready_b", 32'(ready2), 32'd1);
    tick();
    data_in = 8'h0C;
    #1;
    check("bp_d2_ready_full", 32'(ready2), 32'd0);
    check("bp_d2_count_full", 32'(cnt2),   32'd2);
    check("bp_d2_v_held",     32'(v2),     32'd1);
    check("bp_d2_data_held",  32'(data2),  32'h0A);
    tick();
    #1 check("bp_d2_data_stall", 32'(data2), 32'h0A);
    rdy_in = 1'b1;
    #1;
    check("bp_d2_out_a",      32'(data2),  32'h0A);
    check("bp_d2_ready_pass", 32'(ready2), 32'd1);
    tick();
    v_in = 1'b0;
    #1 check("bp_d2_out_b", 32'(data2), 32'h0B);
    tick();
    #1;
    check("bp_d2_out_c_v", 32'(v2),    32'd1);
    check("bp_d2_out_c",   32'(data2), 32'h0C);
    tick();
    #1 check("bp_d2_empty_v", 32'(v2), 32'd0);
    idle(5);

    // Full pass-through: fill, then one in and one out per cycle.
    rdy_in = 1'b0;
    v_in   = 1'b1;
    for (int i = 0; i < 3; i++) begin
      data_in = W'(8'h40 + i);
      tick();
    end
    rdy_in = 1'b1;
    for (int i = 0; i < 4; i++) begin
      data_in = W'(8'h50 + i);
      #1;
      check("pt_d3_ready", 32'(ready3), 32'd1);
      check("pt_d3_v",     32'(v3),     32'd1);
      check("pt_d3_count", 32'(cnt3),   32'd3);
      check("pt_d2_ready", 32'(ready2), 32'd1);
      check("pt_d2_count", 32'(cnt2),   32'd2);
      tick();
    end
    idle(5);

    // Flush with two beats held and 0xFF offered.
    rdy_in = 1'b0;
    v_in   = 1'b1;
    data_in = 8'h61;
    tick();
    data_in = 8'h62;
    tick();
    flush   = 1'b1;
    data_in = 8'hFF;
    #1;
    check("fl_d3_count_pre", 32'(cnt3),   32'd2);
    check("fl_d3_ready",     32'(ready3), 32'd0);
    check("fl_d3_v",         32'(v3),     32'd0);
    check("fl_d2_ready",     32'(ready2), 32'd0);
    check("fl_d2_v",         32'(v2),     32'd0);
    tick();
    flush  = 1'b0;
    v_in   = 1'b0;
    rdy_in = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("fl_d3_v_after", 32'(v3), 32'd0);
      check("fl_d2_v_after", 32'(v2), 32'd0);
      tick();
    end

    // Asynchronous reset with two beats held.
    rdy_in = 1'b0;
    v_in   = 1'b1;
    data_in = 8'h71;
    tick();
    data_in = 8'h72;
    tick();
    v_in = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_d3_v",     32'(v3),    32'd0);
    check("arst_d3_data",  32'(data3), 32'd0);
    check("arst_d3_count", 32'(cnt3),  32'd0);
    check("arst_d2_v",     32'(v2),    32'd0);
    check("arst_d2_data",  32'(data2), 32'd0);
    check("arst_d2_count", 32'(cnt2),  32'd0);
    q3.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    rdy_in = 1'b1;
    for (int c = 0; c < 4; c++) begin
      v_in    = (c == 0);
      data_in = 8'h5A;
      #1 check("arst_latency_d3_v", 32'(v3), 32'(c == 3));
      tick();
    end
    idle(4);

    // Random traffic against the scoreboard.
    for (int i = 0; i < 10000; i++) begin
      flush   = ($urandom_range(0, 19) == 0);
      v_in    = 1'($urandom_range(0, 1));
      rdy_in  = ($urandom_range(0, 3) != 0);
      data_in = W'($urandom);
      tick();
    end
    idle(6);
    check("final_d3_empty", 32'(cnt3), 32'd0);
    check("final_d2_empty", 32'(cnt2), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_pipe_reg

// File: doc/pipe_reg.md
PIPE_REG -- requirements
Module: pipe_reg

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data bits per beat (>=1).
REQ-002 SHALL have parameter DEPTH, default 2, number of register stages (>=1); the parameter check SHALL fail elaboration for DEPTH<1.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port flush_i  input  1  discard all held beats.
REQ-006 SHALL have port v_i  input  1  upstream beat valid.
REQ-007 SHALL have port data_i  input  WIDTH  upstream beat data.
REQ-008 SHALL have port ready_o  output  1  pipe accepts upstream beat this cycle.
REQ-009 SHALL have port v_o  output  1  downstream beat valid.
REQ-010 SHALL have port data_o  output  WIDTH  downstream beat data.
REQ-011 SHALL have port ready_i  input  1  downstream accepts beat.
REQ-012 SHALL have port count_o  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 SHALL hold per stage k (0..DEPTH-1) a valid bit vld[k] and data reg dat[k]; stage 0 is input side, stage DEPTH-1 drives v_o/data_o.
REQ-014 SHALL compute stage readiness rdy[k] = !vld[k] || rdy[k+1], with rdy[DEPTH] = ready_i (combinational backward chain, no bubble penalty).
REQ-015 SHALL drive ready_o = rdy[0] && !flush_i and v_o = vld[DEPTH-1] && !flush_i; data_o = dat[DEPTH-1].
REQ-016 SHALL on a clock edge with rdy[k] set: load vld[k] from the upstream valid (v_i for k=0, vld[k-1] otherwise) and load dat[k] only when that upstream valid is 1.
REQ-017 SHALL leave vld[k]/dat[k] unchanged when rdy[k] is 0 (stall); data_o SHALL stay stable while v_o=1 and ready_i=0.
REQ-018 SHALL give latency of exactly DEPTH cycles from an accepted input beat to v_o when never stalled, and sustain one beat per cycle.
REQ-019 SHALL preserve beat order; no beat duplicated or dropped except by flush.
REQ-020 SHALL on an edge with flush_i=1 clear every vld[k] to 0, ignore v_i (beat not accepted), and leave dat[k] unchanged; flush has priority over all loads.
REQ-021 SHALL drive count_o = popcount(vld) from registered state (not flush-masked); full when count_o=DEPTH, empty when 0.
REQ-022 SHALL when full with ready_i=1 and v_i=1 accept the new beat in the same cycle the output beat leaves (count_o unchanged).
REQ-023 SHALL tolerate v_i toggling without ready_o; upstream beats are held by the sender, not the pipe.

Reset
REQ-024 SHALL on rst_ni=0 asynchronously clear all vld[k] and dat[k] to 0, so v_o=0, data_o=0, count_o=0, ready_o=1 (when flush_i=0).
REQ-025 SHALL discard all in-flight beats on reset mid-operation; first accepted beat after deassertion emerges DEPTH cycles later.
REQ-026 SHALL release reset synchronously externally; no internal synchroniser.

Structure
REQ-027 SHALL implement one stage as sub-module pipe_stage (WIDTH param; vld/dat regs, flush, load logic) instantiated DEPTH times via generate.
REQ-028 SHALL add no new typedefs; a default width constant, if shared, SHALL live in rvga_types.
REQ-029 SHALL remain plain register datapath; no RAM inference, no latches.

Verification
REQ-030 Reset: rst_ni=0 mid-stream with 2 beats held -> v_o=0, data_o=0, count_o=0 immediately, before next edge.
REQ-031 Stream: DEPTH=3, ready_i=1, inputs 0x11,0x22,0x33 on consecutive cycles -> v_o with 0x11,0x22,0x33 on cycles 3,4,5.
REQ-032 Backpressure: DEPTH=2, ready_i=0, push 0xA,0xB,0xC -> ready_o=0 after 2 accepts, count_o=2, data_o held 0xA; ready_i=1 -> 0xA,0xB,then 0xC delivered in order.
REQ-033 Full pass-through: full, v_i=1, ready_i=1 -> ready_o=1, count_o stays DEPTH, one beat in and one out per cycle.
REQ-034 Flush: count_o=2, flush_i=1 with v_i=1 0xFF -> ready_o=0, v_o=0 that cycle, count_o=0 next cycle, 0xFF never appears at data_o.
REQ-035 Random: random v_i/ready_i/flush_i 10k cycles vs scoreboard queue -> order, no loss outside flush, count_o matches model.
